// File: rtl/gate_pkg.sv
// gate_pkg: shared definitions for the gate controller.
// State encoding, FSM type and default data/counter widths.
package gate_pkg;

  localparam int DATA_SIZE_DEF = 14;
  localparam int CNT_SIZE_DEF  = 16;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DELAY   = 2'd1;
  localparam logic [1:0] OPEN    = 2'd2;
  localparam logic [1:0] HOLDOFF = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = IDLE,
    S_DELAY   = DELAY,
    S_OPEN    = OPEN,
    S_HOLDOFF = HOLDOFF
  } state_t;

endpackage

// File: rtl/gate_ctrl_if.sv
// gate_ctrl_if: trigger/config/sample bundle into the gate controller
// and gate/data/status bundle out to the gate buffer.
interface gate_ctrl_if #(
  parameter int DATA_SIZE = gate_pkg::DATA_SIZE_DEF,
  parameter int CNT_SIZE  = gate_pkg::CNT_SIZE_DEF
) ();

  logic                 i_enable;
  logic                 i_trigger;
  logic [CNT_SIZE-1:0]  i_delay;
  logic [CNT_SIZE-1:0]  i_width;
  logic [CNT_SIZE-1:0]  i_holdoff;
  logic [DATA_SIZE-1:0] i_data;
  logic [DATA_SIZE-1:0] o_data;
  logic                 o_gate;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_trig_miss;

  modport master (
    output i_enable, i_trigger, i_delay,
    output i_width, i_holdoff, i_data,
    input  o_data, o_gate, o_busy,
    input  o_done, o_trig_miss
  );

  modport slave (
    input  i_enable, i_trigger, i_delay,
    input  i_width, i_holdoff, i_data,
    output o_data, o_gate, o_busy,
    output o_done, o_trig_miss
  );

endinterface

// File: rtl/gate_counter.sv
// gate_counter: loadable saturating down-counter shared by
// the DELAY, OPEN and HOLDOFF states.
module gate_counter #(
  parameter int CNT_SIZE = gate_pkg::CNT_SIZE_DEF
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_clr,
  input  logic                i_load,
  input  logic [CNT_SIZE-1:0] i_value,
  input  logic                i_dec,
  output logic                o_zero
);

  logic [CNT_SIZE-1:0] r_count;

  // clear beats load beats decrement; decrement stops at zero
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CNT_SIZE'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/gate_ctrl.sv
// gate_ctrl: trigger -> delay -> gate window -> holdoff sequencer
// with a one-stage registered sample path aligned to the gate.
module gate_ctrl #(
  parameter int DATA_SIZE = gate_pkg::DATA_SIZE_DEF,
  parameter int CNT_SIZE  = gate_pkg::CNT_SIZE_DEF
) (
  input  logic       i_clock,
  input  logic       i_reset,
  gate_ctrl_if.slave bus
);

  import gate_pkg::*;

  localparam logic [CNT_SIZE-1:0] ONE = CNT_SIZE'(1);

  state_t               r_state;
  logic [CNT_SIZE-1:0]  r_width;
  logic [CNT_SIZE-1:0]  r_hold;
  logic [DATA_SIZE-1:0] r_data;
  logic                 r_gate;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_done_pend;
  logic                 r_trig_miss;

  logic                w_accept;
  logic                w_zero;
  logic                w_clr;
  logic                w_load;
  logic                w_dec;
  logic [CNT_SIZE-1:0] w_val;

  assign w_accept = bus.i_enable & bus.i_trigger & (r_state == S_IDLE);

  gate_counter #(.CNT_SIZE(CNT_SIZE)) u_cnt (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clr   (w_clr),
    .i_load  (w_load),
    .i_value (w_val),
    .i_dec   (w_dec),
    .o_zero  (w_zero)
  );

  // counter control: load (value-1) on entry to each timed state
  always_comb begin
    w_clr  = ~bus.i_enable;
    w_load = 1'b0;
    w_dec  = 1'b0;
    w_val  = '0;
    if (bus.i_enable) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (bus.i_width != '0) begin
              w_load = 1'b1;
              w_val  = (bus.i_delay != '0) ? bus.i_delay - ONE
                                           : bus.i_width - ONE;
            end else if (bus.i_holdoff != '0) begin
              w_load = 1'b1;
              w_val  = bus.i_holdoff - ONE;
            end
          end
        end
        S_DELAY: begin
          if (w_zero) begin
            w_load = 1'b1;
            w_val  = r_width - ONE;
          end else begin
            w_dec = 1'b1;
          end
        end
        S_OPEN: begin
          if (w_zero) begin
            w_load = (r_hold != '0);
            w_val  = r_hold - ONE;
          end else begin
            w_dec = 1'b1;
          end
        end
        S_HOLDOFF: begin
          w_dec = 1'b1;
        end
      endcase
    end
  end

  // sequencer state plus registered outputs, which lag the state by one edge
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_width     <= '0;
      r_hold      <= '0;
      r_data      <= '0;
      r_gate      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_done_pend <= 1'b0;
      r_trig_miss <= 1'b0;
    end else begin
      r_data      <= bus.i_data;
      r_trig_miss <= bus.i_trigger & ~w_accept;
      if (!bus.i_enable) begin
        r_state     <= S_IDLE;
        r_gate      <= 1'b0;
        r_busy      <= 1'b0;
        r_done      <= 1'b0;
        r_done_pend <= 1'b0;
      end else begin
        r_gate      <= (r_state == S_OPEN);
        r_busy      <= (r_state != S_IDLE);
        r_done      <= r_done_pend;
        r_done_pend <= 1'b0;
        unique case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_width <= bus.i_width;
              r_hold  <= bus.i_holdoff;
              if (bus.i_width == '0) begin
                r_done_pend <= 1'b1;
                r_state <= (bus.i_holdoff != '0) ? S_HOLDOFF : S_IDLE;
              end else if (bus.i_delay != '0) begin
                r_state <= S_DELAY;
              end else begin
                r_state <= S_OPEN;
              end
            end
          end
          S_DELAY: begin
            if (w_zero) r_state <= S_OPEN;
          end
          S_OPEN: begin
            if (w_zero) begin
              r_done_pend <= 1'b1;
              r_state <= (r_hold != '0) ? S_HOLDOFF : S_IDLE;
            end
          end
          S_HOLDOFF: begin
            if (w_zero) r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.o_data      = r_data;
  assign bus.o_gate      = r_gate;
  assign bus.o_busy      = r_busy;
  assign bus.o_done      = r_done;
  assign bus.o_trig_miss = r_trig_miss;

endmodule

// File: doc/gate_ctrl.md
Name: gate_ctrl

Overview:
- Generates the gate strobe and the aligned data stream that feed the gate buffer.
- On an accepted trigger it waits a programmable delay, then holds the gate open for a programmable width, then enforces a holdoff before rearming.
- It also registers the sample stream, so data and gate reach the buffer on the same clock edge.
- It sits between the acquisition front-end (14-bit samples) and the gate buffer.

Parameters:
- DATA_SIZE, 14, width of the sample data path.
- CNT_SIZE, 16, width of the delay, width and holdoff counters and their configuration inputs.

Ports:
- i_clock, input, 1, system clock; all logic is rising-edge.
- i_reset, input, 1, asynchronous active-low reset.
- i_enable, input, 1, block enable. Low forces IDLE and aborts any sequence.
- i_trigger, input, 1, trigger request, sampled every cycle (level is sampled; a pulse is expected).
- i_delay, input, CNT_SIZE, cycles from trigger acceptance to gate open.
- i_width, input, CNT_SIZE, gate-open duration in cycles.
- i_holdoff, input, CNT_SIZE, dead time after gate close before a new trigger is accepted.
- i_data, input, DATA_SIZE, incoming sample stream.
- o_data, output, DATA_SIZE, i_data delayed by one register stage.
- o_gate, output, 1, gate strobe to the gate buffer.
- o_busy, output, 1, high in any state other than IDLE.
- o_done, output, 1, one-cycle pulse when a gate window completes normally.
- o_trig_miss, output, 1, one-cycle pulse when a trigger arrives and is not accepted.

Behaviour:
- Reset (asynchronous, i_reset=0):
  - state = IDLE and counters = 0.
  - o_gate, o_busy, o_done and o_trig_miss = 0; o_data = 0.
  - Release is synchronous to i_clock.
- All outputs are registered. o_data(n+1) = i_data(n) unconditionally, independent of state and enable.
- States: IDLE, DELAY, OPEN, HOLDOFF. A single loadable down-counter serves all timed states; it is loaded with (value-1) on entry.
- IDLE:
  - If i_enable=1 and i_trigger=1, the trigger is accepted. i_delay, i_width and i_holdoff are latched at this edge; later changes have no effect on the running sequence.
  - Next state on acceptance:
    - i_delay>0 and i_width>0: DELAY.
    - i_delay=0 and i_width>0: OPEN.
    - i_width=0: HOLDOFF, with o_done pulsed; the gate is never opened.
- Timing: trigger sampled at edge T.
  - o_gate rises at edge T+1+D, where D = i_delay.
  - o_gate stays high for exactly W = i_width cycles.
- DELAY: counts D cycles, then OPEN.
- OPEN:
  - o_gate=1 throughout.
  - On the last cycle, go to HOLDOFF if H>0, otherwise IDLE.
  - o_done=1 in the first cycle after o_gate falls.
- HOLDOFF: counts H = i_holdoff cycles, then IDLE. With H=0 the block can accept a new trigger on the edge where o_gate falls.
- o_trig_miss:
  - Pulses for one cycle when i_trigger=1 while the state is not IDLE (the trigger is dropped).
  - Also pulses when i_trigger=1 while i_enable=0.
  - An accepted trigger never raises it.
- Abort on i_enable=0 in any state:
  - Next edge: state=IDLE, o_gate=0, no o_done.
  - The counter is cleared.
- Simultaneous events: the trigger on the same edge the block re-enters IDLE is missed (o_trig_miss=1); acceptance requires the state to already be IDLE.
- Counters saturate at 0 and never wrap. Maximum values: D, W and H each up to 2^CNT_SIZE-1.
- Reset mid-sequence: immediate return to reset values, regardless of o_gate.

Decomposition:
- Shared package gate_pkg holds:
  - the state encoding localparams (IDLE=2'd0, DELAY=2'd1, OPEN=2'd2, HOLDOFF=2'd3);
  - default DATA_SIZE=14 and CNT_SIZE=16.
- One sub-module, gate_counter: a CNT_SIZE loadable down-counter with load, enable, clear and a zero flag, using the same clock and reset.

Test Plan:
- Basic window: enable=1, D=3, W=5, H=4, trigger at edge 10 -> o_gate high at edges 14..18; o_done at 19; o_busy low from edge 23; o_data always equals the previous-cycle i_data (e.g. 4000 then 1111).
- Zero delay/holdoff: D=0, W=2, H=0, trigger at edge 5 -> o_gate at 6..7; second trigger at edge 8 accepted; o_gate at 9..10.
- Missed triggers: D=2, W=4, H=3, triggers at edges 0, 3 and 9 -> o_gate at 3..6; o_trig_miss pulses for the triggers at 3 and 9; next trigger at 10 accepted.
- Width zero: W=0, D=7, trigger -> o_gate never high; o_done at next edge; HOLDOFF for H cycles.
- Abort and config latch: D=1, W=10, trigger; change i_width to 2 at edge 2 -> still a 10-cycle gate. A second run with i_enable dropped at gate cycle 4 -> o_gate low next edge, no o_done.
- Reset mid-gate: assert i_reset asynchronously while o_gate=1 -> all outputs 0 immediately without a clock edge; after release the block is idle and accepts a trigger normally.
